// File: rtl/data_memory_ctrl_pkg.sv
// Shared encodings for the data memory controller: FSM states, RV32I
// load/store funct3 values, default latency and the latched request record.
package data_memory_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // funct3 encodings; stores reuse the B/H/W codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int LATENCY_DEF = 5;

  // Request fields captured at accept; the address is kept separately
  // because only its low ADDR_W bits are stored.
  typedef struct packed {
    logic        wr;
    logic [2:0]  func3;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/data_memory_ctrl_if.sv
// CPU <-> data memory bus. The CPU drives the request side, the memory
// answers with the stall, load result and error pulse.
interface data_memory_ctrl_if;
  logic        READ;
  logic        WRITE;
  logic [2:0]  FUNC3;
  logic [31:0] ADDRESS;
  logic [31:0] WRITEDATA;
  logic [31:0] READDATA;
  logic        BUSYWAIT;
  logic        ACCESS_ERR;

  modport master (
    output READ, WRITE, FUNC3, ADDRESS, WRITEDATA,
    input  READDATA, BUSYWAIT, ACCESS_ERR
  );

  modport slave (
    input  READ, WRITE, FUNC3, ADDRESS, WRITEDATA,
    output READDATA, BUSYWAIT, ACCESS_ERR
  );
endinterface

// File: rtl/data_memory_ctrl_lane_align.sv
// Combinational lane steering for one access: store byte enables and
// replicated write lanes, load extract/extend, and misalign/illegal detect.
// Works on the aligned 32-bit word containing the access.
module data_memory_ctrl_lane_align
  import data_memory_ctrl_pkg::*;
(
  input  logic        is_wr,
  input  logic [2:0]  func3,
  input  logic [1:0]  a_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wlane,
  output logic [31:0] rdata,
  output logic        err
);

  logic [31:0] sh;

  // Move the addressed byte down to lane 0 so extraction is uniform.
  assign sh = rword >> {a_lo, 3'b000};

  // Decode width/sign; errors suppress both write enables and load data.
  always_comb begin
    be    = 4'b0000;
    wlane = 32'h0;
    rdata = 32'h0;
    err   = 1'b0;
    if (is_wr) begin
      unique case (func3)
        F3_B: begin
          be    = 4'b0001 << a_lo;
          wlane = {4{wdata[7:0]}};
        end
        F3_H: begin
          err   = a_lo[0];
          be    = 4'b0011 << a_lo;
          wlane = {2{wdata[15:0]}};
        end
        F3_W: begin
          err   = |a_lo;
          be    = 4'b1111;
          wlane = wdata;
        end
        default: err = 1'b1;
      endcase
      if (err) be = 4'b0000;
    end else begin
      unique case (func3)
        F3_B:  rdata = {{24{sh[7]}}, sh[7:0]};
        F3_BU: rdata = {24'h0, sh[7:0]};
        F3_H: begin
          err   = a_lo[0];
          rdata = {{16{sh[15]}}, sh[15:0]};
        end
        F3_HU: begin
          err   = a_lo[0];
          rdata = {16'h0, sh[15:0]};
        end
        F3_W: begin
          err   = |a_lo;
          rdata = rword;
        end
        default: err = 1'b1;
      endcase
      if (err) rdata = 32'h0;
    end
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Multi-cycle byte-addressed data memory behind the MEM stage. A request is
// accepted in IDLE, held for LATENCY cycles of BUSYWAIT, committed on the
// last busy edge and reported in a one-cycle DONE state.
module data_memory_ctrl
  import data_memory_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  data_memory_ctrl_if.slave bus
);

  localparam logic [3:0] CNT_LAST = 4'(LATENCY - 1);

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  req_t              req;
  logic [ADDR_W-1:0] addr_q;
  logic              busy, accept, commit;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic [7:0]        mem [0:2**ADDR_W-1];
  logic [ADDR_W-1:0] base;
  logic [31:0]       rword, wlane, rext;
  logic [3:0]        be;
  logic              err;

  // Aligned accesses never cross a word, so the word at base covers all lanes.
  assign base   = {addr_q[ADDR_W-1:2], 2'b00};
  assign rword  = {mem[base + ADDR_W'(3)], mem[base + ADDR_W'(2)],
                   mem[base + ADDR_W'(1)], mem[base]};
  assign accept = (state == ST_IDLE) && (bus.READ || bus.WRITE);
  assign commit = (state == ST_BUSY) && (cnt == CNT_LAST);

  data_memory_ctrl_lane_align u_align (
    .is_wr (req.wr),
    .func3 (req.func3),
    .a_lo  (addr_q[1:0]),
    .wdata (req.wdata),
    .rword (rword),
    .be    (be),
    .wlane (wlane),
    .rdata (rext),
    .err   (err)
  );

  // Next state and stall; IDLE stalls combinationally on a fresh request.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        busy = bus.READ | bus.WRITE;
        if (busy) state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        busy = 1'b1;
        if (cnt == CNT_LAST) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (!RESET) busy = 1'b0;
  end

  // State, latency counter, request latches and load/error result registers.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      req     <= '0;
      addr_q  <= '0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= commit & err;
      unique case (state)
        ST_IDLE: if (accept) begin
          cnt       <= 4'd1;
          req.wr    <= bus.WRITE;
          req.func3 <= bus.FUNC3;
          req.wdata <= bus.WRITEDATA;
          addr_q    <= bus.ADDRESS[ADDR_W-1:0];
        end
        ST_BUSY: cnt <= cnt + 4'd1;
        default: cnt <= 4'd0;
      endcase
      if (commit && !req.wr) rdata_q <= rext;
    end
  end

  // Byte array write port; an erroring store has no enables set.
  always_ff @(posedge CLK) begin
    if (RESET && commit && req.wr) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[base + ADDR_W'(i)] <= wlane[8*i +: 8];
    end
  end

  assign bus.BUSYWAIT   = busy;
  assign bus.READDATA   = rdata_q;
  assign bus.ACCESS_ERR = err_q;

endmodule
